// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: FSM encoding and
// default sizing constants.
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  // CLEAR zeroes the array one entry per cycle; RUN accepts traffic.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set by issue and
// cleared by writeback (issue wins on a collision), with a registered
// population count.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_en,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic                       clr_en,
  input  logic [ADDR_W-1:0]          clr_addr,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  // Next busy vector: clear first so a same-address set overrides it; the
  // zero register is pinned idle. Count is taken from the next-state vector
  // so the registered count always matches the registered bits.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[k]};
  end

  // Busy bits and count register; reset drops every pending producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, single-write register file with write-through bypass, a
// busy-bit scoreboard and a self-clearing start-up sequence.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     ready,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rf_q [DEPTH];
  logic [DEPTH-1:0]    busy_vec;
  logic                wr_acc, iss_acc;

  // Traffic is only honoured once the clear sequence has finished, and the
  // zero register never takes a write or becomes pending.
  assign wr_acc  = ready_q && we && (wr_addr != '0);
  assign iss_acc = ready_q && iss_valid && (iss_addr != '0);

  // Clear/run sequencer; ready is registered and rises on the edge that
  // retires the last clear write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == ADDR_W'(DEPTH-1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:   state_q <= ST_RUN;
        default:  state_q <= ST_CLEAR;
      endcase
    end
  end

  // Storage: zero-fill while clearing, otherwise take accepted writes.
  always_ff @(posedge clk) begin
    if (!ready_q)
      rf_q[clr_ptr_q] <= '0;
    else if (wr_acc)
      rf_q[wr_addr] <= wr_data;
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_acc),
    .set_addr (iss_addr),
    .clr_en   (wr_acc),
    .clr_addr (wr_addr),
    .busy     (busy_vec),
    .busy_cnt (busy_cnt)
  );

  // Combinational read ports with same-cycle bypass of the accepted write.
  // A bypassed operand is no longer waiting, so its busy flag is masked.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp;
    assign a   = rd_addr[i*ADDR_W +: ADDR_W];
    assign byp = wr_acc && (wr_addr == a);
    assign rd_data[i*DATA_W +: DATA_W] = (!ready_q || (a == '0)) ? '0 :
                                         byp ? wr_data : rf_q[a];
    assign rd_busy[i] = ready_q && busy_vec[a] && !byp;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              iss_valid = 1'b0;
  logic [AW-1:0]     iss_addr = '0;
  logic              ready;
  logic [AW:0]       busy_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .ready     (ready),
    .busy_cnt  (busy_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Array contents, pending set and number of clear cycles elapsed.
  logic [DW-1:0] mrf   [DEPTH];
  bit            mbusy [DEPTH];
  int            clr_cnt;

  always @(posedge clk) begin
    if (rst) begin
      clr_cnt <= 0;
      for (int k = 0; k < DEPTH; k++) begin
        mrf[k]   <= '0;
        mbusy[k] <= 1'b0;
      end
    end else if (clr_cnt < DEPTH) begin
      clr_cnt <= clr_cnt + 1;
    end else begin
      if (we && wr_addr != 0) begin
        mrf[wr_addr]   <= wr_data;
        mbusy[wr_addr] <= 1'b0;
      end
      if (iss_valid && iss_addr != 0) mbusy[iss_addr] <= 1'b1;
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    logic          mready;
    logic [AW-1:0] a;
    logic          byp;
    logic [DW-1:0] ed;
    logic          eb;
    int            pc;
    mready = !rst && (clr_cnt == DEPTH);
    pc = 0;
    for (int k = 0; k < DEPTH; k++) pc += int'(mbusy[k]);
    chk("ready", {63'd0, ready}, {63'd0, mready});
    chk("busy_cnt", 64'(busy_cnt), rst ? 64'd0 : 64'(pc));
    for (int i = 0; i < NRD; i++) begin
      a   = rd_addr[i*AW +: AW];
      byp = mready && we && (wr_addr != 0) && (wr_addr == a);
      ed  = (!mready || a == 0) ? '0 : (byp ? wr_data : mrf[a]);
      eb  = mready && mbusy[a] && !byp;
      chk("rd_data", 64'(rd_data[i*DW +: DW]), 64'(ed));
      chk("rd_busy", {63'd0, rd_busy[i]}, {63'd0, eb});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
    we = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_addr = {AW'(p1), AW'(p0)};
  endtask

  // Counts negedges with ready low after release; bounded.
  task automatic count_clear(output int n);
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Start-up: 32 cycles not ready, then every register reads zero.
    count_clear(n);
    chk("clear_cycles", 64'(n), 64'd32);
    for (int a = 0; a < DEPTH; a++) begin
      next_cycle(); set_rd(a, DEPTH-1-a);
      @(negedge clk);
      chk("init_zero", 64'(rd_data), 64'd0);
    end

    // Bypass then stored value.
    next_cycle(); we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(5, 0);
    @(negedge clk);
    chk("bypass5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk("stored5", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);

    // Writes to register 0 are discarded.
    next_cycle(); we = 1; wr_addr = 0; wr_data = 32'h12345678; set_rd(5, 0);
    @(negedge clk);
    chk("r0_port1", 64'(rd_data[2*DW-1:DW]), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("r0_port1_after", 64'(rd_data[2*DW-1:DW]), 64'd0);
    chk("r0_cnt", 64'(busy_cnt), 64'd0);

    // Issue 7, observe busy, then writeback bypass clears it.
    next_cycle(); iss_valid = 1; iss_addr = 7;
    next_cycle(); set_rd(7, 0);
    @(negedge clk);
    chk("busy7", {63'd0, rd_busy[0]}, 64'd1);
    chk("cnt_after_iss7", 64'(busy_cnt), 64'd1);
    next_cycle(); we = 1; wr_addr = 7; wr_data = 32'hA5;
    @(negedge clk);
    chk("wb7_busy", {63'd0, rd_busy[0]}, 64'd0);
    chk("wb7_data", 64'(rd_data[DW-1:0]), 64'hA5);
    next_cycle();
    @(negedge clk);
    chk("cnt_after_wb7", 64'(busy_cnt), 64'd0);

    // Simultaneous issue and write: set wins, data still lands.
    next_cycle(); iss_valid = 1; iss_addr = 9; we = 1; wr_addr = 9; wr_data = 32'h1;
    next_cycle(); set_rd(9, 0);
    @(negedge clk);
    chk("coll9_data", 64'(rd_data[DW-1:0]), 64'h1);
    chk("coll9_busy", {63'd0, rd_busy[0]}, 64'd1);
    chk("coll9_cnt", 64'(busy_cnt), 64'd1);

    // Retire 9, seed rf[3], issue 3 and 4, then reset mid-run.
    next_cycle(); we = 1; wr_addr = 9; wr_data = 32'h0;
    next_cycle(); we = 1; wr_addr = 3; wr_data = 32'h33;
    next_cycle(); iss_valid = 1; iss_addr = 3;
    next_cycle(); iss_valid = 1; iss_addr = 4;
    next_cycle(); set_rd(3, 4);
    @(negedge clk);
    chk("cnt_pre_rst", 64'(busy_cnt), 64'd2);
    chk("rf3_pre_rst", 64'(rd_data[DW-1:0]), 64'h33);
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    count_clear(n);
    chk("reclear_cycles", 64'(n), 64'd32);
    chk("rf3_after_rst", 64'(rd_data[DW-1:0]), 64'd0);
    chk("cnt_after_rst", 64'(busy_cnt), 64'd0);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 1500; c++) begin
      logic [AW-1:0] p0, p1;
      next_cycle();
      rst       = ($urandom_range(0, 299) == 0);
      we        = $urandom_range(0, 1);
      wr_addr   = AW'($urandom);
      wr_data   = $urandom;
      iss_valid = ($urandom_range(0, 9) < 4);
      iss_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      p0 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      p1 = ($urandom_range(0, 2) == 0) ? iss_addr : AW'($urandom);
      rd_addr = {p1, p0};
    end
    next_cycle(); rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2: number of independent read ports.
REQ-004 One clock and asynchronous active-high reset; clock port clk, reset port rst.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 rd_data  out  NRD*DATA_W  read data, packed the same way as rd_addr.
REQ-009 rd_busy  out  NRD  per read port: operand has an outstanding unwritten producer.
REQ-010 we  in  1  write enable.
REQ-011 wr_addr  in  ADDR_W  write address.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 iss_valid  in  1  issue strobe: marks iss_addr as pending (scoreboard set).
REQ-014 iss_addr  in  ADDR_W  destination register of the issuing instruction.
REQ-015 ready  out  1  high when the clear sequence is complete and the file accepts traffic.
REQ-016 busy_cnt  out  ADDR_W+1  number of registers currently marked busy.

Function
REQ-017 Register 0 SHALL read as 0 on every port, ignore writes, and never become busy.
REQ-018 Reads SHALL be combinational: rd_data[i] = rf[rd_addr[i]], zero latency.
REQ-019 Write-through bypass: if we=1, ready=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] SHALL equal wr_data in the same cycle.
REQ-020 With we=1, ready=1 and wr_addr!=0, rf[wr_addr] SHALL take wr_data at the next rising edge.
REQ-021 rd_busy[i] = busy[rd_addr[i]] AND NOT the bypass condition of REQ-019 for port i.
REQ-022 iss_valid=1, ready=1, iss_addr!=0: busy[iss_addr] SHALL be set at the next edge.
REQ-023 A write accepted under REQ-020 SHALL clear busy[wr_addr] at the same edge.
REQ-024 iss_valid and write to the same address in the same cycle: set wins; the register ends busy with data updated.
REQ-025 busy_cnt SHALL equal the population count of busy after every edge; no overflow, because the maximum is DEPTH-1.
REQ-026 FSM states: CLEAR and RUN. CLEAR writes 0 to rf[clr_ptr] and increments clr_ptr by one each cycle; after writing DEPTH-1 it moves to RUN.
REQ-027 In CLEAR: ready=0, we and iss_valid ignored, rd_data=0, rd_busy=0.
REQ-028 The clear sequence SHALL take exactly DEPTH cycles after rst deassertion; ready rises on the edge that completes the last clear write.

Reset
REQ-029 rst=1 SHALL asynchronously force state CLEAR, clr_ptr=0, all busy bits 0, busy_cnt=0 and ready=0; register contents are not reset directly.
REQ-030 rst asserted mid-operation (in RUN or partway through CLEAR) SHALL abandon the current activity and restart the full clear sequence after release.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (CLEAR, RUN) and the default parameter constants.
REQ-032 The scoreboard (busy bits, set/clear priority, busy_cnt) SHALL be a sub-module regfile_scoreboard; storage, bypass and FSM stay in regfile_sb.
REQ-033 The implementation SHALL target 120-400 lines of RTL with no vendor primitives.

Verification
REQ-034 Release rst, defaults -> ready=0 for 32 cycles, then 1; all registers read 0.
REQ-035 Write rf[5]=0xDEADBEEF while rd_addr port 0=5 -> rd_data port 0 = 0xDEADBEEF in the same cycle; rf[5]=0xDEADBEEF after the edge.
REQ-036 Write rf[0]=0x12345678 -> port 1 at address 0 reads 0; busy_cnt stays 0.
REQ-037 Issue 7, then read 7 -> rd_busy=1, busy_cnt=1; in the cycle of write 7=0xA5 -> rd_busy=0, rd_data=0xA5; next cycle busy_cnt=0.
REQ-038 Issue 9 and write 9=0x1 in the same cycle -> after the edge rf[9]=0x1, busy[9]=1, busy_cnt=1.
REQ-039 Issue 3 and 4, assert rst for 1 cycle, then release -> busy_cnt=0, ready=0 for 32 cycles, rf[3] reads 0.
